// File: rtl/bus_dma_master_if.sv
// Bus bundle for the DMA: register-window responder side plus initiator side.
// master = DMA view, slave = system/bus view.
interface bus_dma_master_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              s_cs;
    logic              s_as;
    logic              s_rw;
    logic [1:0]        s_addr;
    logic [DATA_W-1:0] s_wr_data;
    logic [DATA_W-1:0] s_rd_data;
    logic              s_rdy;

    logic              m_req;
    logic              m_get;
    logic [ADDR_W-1:0] m_addr;
    logic              m_as;
    logic              m_rw;
    logic [DATA_W-1:0] m_wr_data;
    logic [DATA_W-1:0] m_rd_data;
    logic              m_ready;

    modport master (
        input  s_cs, s_as, s_rw, s_addr, s_wr_data,
        output s_rd_data, s_rdy,
        output m_req, m_addr, m_as, m_rw, m_wr_data,
        input  m_get, m_rd_data, m_ready
    );

    modport slave (
        output s_cs, s_as, s_rw, s_addr, s_wr_data,
        input  s_rd_data, s_rdy,
        input  m_req, m_addr, m_as, m_rw, m_wr_data,
        output m_get, m_rd_data, m_ready
    );
endinterface

// File: rtl/bus_dma_master.sv
// Single-channel word-copy DMA: register window on the slave side,
// read-then-write beat pairs on the master side, burst-limited grants.
module bus_dma_master #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int BURST  = 8
) (
    input  logic             clk,
    input  logic             rst,
    bus_dma_master_if.master bus,
    output logic             irq_o
);
    localparam int BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RD, S_WR, S_NEXT, S_REL, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] src_r, dst_r, cur_src, cur_dst;
    logic [LEN_W-1:0]  len_r, cur_len;
    logic [BW-1:0]     beat_q;
    logic [DATA_W-1:0] buf_q, rd_q, rd_mux;
    logic              wr_pend, done_q, irq_en, abort_q, rdy_q;
    logic              busy, s_hit, s_wr, wr_ctrl, start_go, abort_go;
    logic              m_req, m_as, m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wr_data;
    logic              unused_bits;

    assign busy     = (state_q != S_IDLE);
    assign s_hit    = bus.s_cs & bus.s_as;
    assign s_wr     = s_hit & ~bus.s_rw;
    assign wr_ctrl  = s_wr & (bus.s_addr == 2'd3);
    assign start_go = wr_ctrl & bus.s_wr_data[0] & ~busy;
    assign abort_go = wr_ctrl & bus.s_wr_data[4] & busy;
    assign unused_bits = ^bus.s_wr_data;

    always_comb begin
        rd_mux = '0;
        case (bus.s_addr)
            2'd0:    rd_mux[ADDR_W-1:0] = src_r;
            2'd1:    rd_mux[ADDR_W-1:0] = dst_r;
            2'd2:    rd_mux[LEN_W-1:0]  = len_r;
            default: rd_mux[4:0] = {1'b0, irq_en, done_q, busy, 1'b0};
        endcase
    end

    // Register window and control flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_r   <= '0;
            dst_r   <= '0;
            len_r   <= '0;
            rd_q    <= '0;
            rdy_q   <= 1'b0;
            irq_en  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            rdy_q <= s_hit;
            rd_q  <= (s_hit && bus.s_rw) ? rd_mux : '0;
            if (s_wr && !busy) begin
                case (bus.s_addr)
                    2'd0:    src_r <= bus.s_wr_data[ADDR_W-1:0];
                    2'd1:    dst_r <= bus.s_wr_data[ADDR_W-1:0];
                    2'd2:    len_r <= bus.s_wr_data[LEN_W-1:0];
                    default: ;
                endcase
            end
            if (wr_ctrl)
                irq_en <= bus.s_wr_data[3];
            // FSM set takes priority over a concurrent W1C
            if (state_q == S_DONE)
                done_q <= 1'b1;
            else if (start_go || (wr_ctrl && bus.s_wr_data[2]))
                done_q <= 1'b0;
            if (state_q == S_IDLE)
                abort_q <= 1'b0;
            else if (abort_go)
                abort_q <= 1'b1;
        end
    end

    // Working counters and the read-data buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_src <= '0;
            cur_dst <= '0;
            cur_len <= '0;
            beat_q  <= '0;
            buf_q   <= '0;
            wr_pend <= 1'b0;
        end else begin
            if (start_go) begin
                cur_src <= src_r;
                cur_dst <= dst_r;
                cur_len <= len_r;
                beat_q  <= '0;
                wr_pend <= 1'b0;
            end
            if (state_q == S_RD && bus.m_ready) begin
                buf_q   <= bus.m_rd_data;
                wr_pend <= 1'b1;
            end
            if (state_q == S_NEXT) begin
                cur_src <= cur_src + ADDR_W'(1);
                cur_dst <= cur_dst + ADDR_W'(1);
                cur_len <= cur_len - LEN_W'(1);
                beat_q  <= beat_q + BW'(1);
                wr_pend <= 1'b0;
            end
            if (state_q == S_REL)
                beat_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        m_req     = 1'b0;
        m_as      = 1'b0;
        m_rw      = 1'b0;
        m_addr    = '0;
        m_wr_data = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start_go)
                    state_d = (len_r == '0) ? S_DONE : S_REQ;
            end
            S_REQ: begin
                m_req = 1'b1;
                // A grant lost mid-write resumes at the write, buf intact
                if (bus.m_get)
                    state_d = wr_pend ? S_WR : S_RD;
            end
            S_RD: begin
                m_req  = 1'b1;
                m_as   = 1'b1;
                m_rw   = 1'b1;
                m_addr = cur_src;
                if (bus.m_ready)     state_d = S_WR;
                else if (!bus.m_get) state_d = S_REQ;
            end
            S_WR: begin
                m_req     = 1'b1;
                m_as      = 1'b1;
                m_addr    = cur_dst;
                m_wr_data = buf_q;
                if (bus.m_ready)     state_d = S_NEXT;
                else if (!bus.m_get) state_d = S_REQ;
            end
            S_NEXT: begin
                m_req = 1'b1;
                if (cur_len == LEN_W'(1)) state_d = S_DONE;
                else if (abort_q)         state_d = S_IDLE;
                else if (beat_q == BEAT_LAST) state_d = S_REL;
                else                      state_d = S_RD;
            end
            S_REL:   state_d = S_REQ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.m_req     = m_req;
    assign bus.m_as      = m_as;
    assign bus.m_rw      = m_rw;
    assign bus.m_addr    = m_addr;
    assign bus.m_wr_data = m_wr_data;
    assign bus.s_rdy     = rdy_q;
    assign bus.s_rd_data = rd_q;
    assign irq_o         = done_q & irq_en;
endmodule
